// File: rtl/ws2812_fb_ctrl.sv
// Frame-buffer controller and display arbiter for ws2812_matrix.
// Tear-free host commits and an overlay owner with a minimum hold time.
module ws2812_fb_ctrl #(
  parameter int CLK_FRQ     = 27_000_000,
  parameter int FRAME_HZ    = 50,
  parameter int LEDS        = 60,
  parameter int HOLD_FRAMES = 25,
  parameter int AW          = $clog2(LEDS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [2:0]      wr_data,
  input  logic            clr,
  input  logic            commit,
  output logic            busy,
  input  logic            ovl_req,
  input  logic [LEDS-1:0] ovl_r,
  input  logic [LEDS-1:0] ovl_g,
  input  logic [LEDS-1:0] ovl_b,
  output logic            ovl_gnt,
  output logic            frame_tick,
  output logic [LEDS-1:0] r,
  output logic [LEDS-1:0] g,
  output logic [LEDS-1:0] b
);

  localparam int DIV = CLK_FRQ / FRAME_HZ;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [7:0] HOLD = 8'(HOLD_FRAMES);

  typedef enum logic {
    HOST,
    OVL
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] fcnt;
  logic pend;
  logic [7:0] hold, hold_nxt;
  logic [LEDS-1:0] sh_r, sh_g, sh_b;
  logic [LEDS-1:0] hd_r, hd_g, hd_b;
  logic [LEDS-1:0] od_r, od_g, od_b;
  logic [LEDS-1:0] hd_r_nxt, hd_g_nxt, hd_b_nxt;
  logic [LEDS-1:0] od_r_nxt, od_g_nxt, od_b_nxt;
  logic wr_ok;

  assign busy    = pend;
  assign ovl_gnt = (state == OVL);
  assign wr_ok   = wr_en && (32'(wr_addr) < LEDS);

  // Frame timer; tick is high the cycle after the last count.
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt       <= '0;
      frame_tick <= 1'b0;
    end else begin
      fcnt       <= (fcnt == LAST) ? '0 : fcnt + 1'b1;
      frame_tick <= (fcnt == LAST);
    end
  end

  // Shadow bitmap; clear beats a same-cycle pixel write.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sh_r <= '0;
      sh_g <= '0;
      sh_b <= '0;
    end else if (wr_ok) begin
      sh_r[wr_addr] <= wr_data[2];
      sh_g[wr_addr] <= wr_data[1];
      sh_b[wr_addr] <= wr_data[0];
    end
  end

  // Next-state, hold counter and buffer selection for a tick edge.
  // Release is judged on the incremented hold, so the overlay owns
  // exactly HOLD_FRAMES frames after the grant tick.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    unique case (state)
      HOST: begin
        if (ovl_req) begin
          state_nxt = OVL;
          hold_nxt  = '0;
        end
      end
      OVL: begin
        hold_nxt = (hold == HOLD) ? hold : hold + 8'd1;
        if (hold_nxt == HOLD && !ovl_req) begin
          state_nxt = HOST;
        end
      end
    endcase
    hd_r_nxt = pend ? sh_r : hd_r;
    hd_g_nxt = pend ? sh_g : hd_g;
    hd_b_nxt = pend ? sh_b : hd_b;
    od_r_nxt = ovl_req ? ovl_r : od_r;
    od_g_nxt = ovl_req ? ovl_g : od_g;
    od_b_nxt = ovl_req ? ovl_b : od_b;
  end

  // Commit handshake; a commit in the tick cycle re-arms pend.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
      hd_r <= '0;
      hd_g <= '0;
      hd_b <= '0;
    end else begin
      if (frame_tick) begin
        hd_r <= hd_r_nxt;
        hd_g <= hd_g_nxt;
        hd_b <= hd_b_nxt;
      end
      if (commit) begin
        pend <= 1'b1;
      end else if (frame_tick) begin
        pend <= 1'b0;
      end
    end
  end

  // Arbiter state, overlay buffer and display outputs on tick edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HOST;
      hold  <= '0;
      od_r  <= '0;
      od_g  <= '0;
      od_b  <= '0;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else if (frame_tick) begin
      state <= state_nxt;
      hold  <= hold_nxt;
      od_r  <= od_r_nxt;
      od_g  <= od_g_nxt;
      od_b  <= od_b_nxt;
      if (state_nxt == OVL) begin
        r <= od_r_nxt;
        g <= od_g_nxt;
        b <= od_b_nxt;
      end else begin
        r <= hd_r_nxt;
        g <= hd_g_nxt;
        b <= hd_b_nxt;
      end
    end
  end

endmodule
